// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_ctrl
//  Description : Time-multiplexed scan of NDIG 4-bit digits onto one shared
//                7-segment decoder. Each digit slot lasts SCAN_DIV cycles and
//                ends with DEAD blanked cycles. New values are double-buffered
//                and swapped in only at a frame boundary.
//  Options     : define SEG_SCAN_LZB_EN to enable leading-zero blanking.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
   parameter int NDIG     = 4,
   parameter int SCAN_DIV = 25,
   parameter int DEAD     = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic [4*NDIG-1:0] digits_in,
   input  logic              load,
   output logic              busy,
   output logic [3:0]        hex_out,
   output logic [NDIG-1:0]   dig_en,
   output logic              frame_start
);

   localparam int IW = $clog2(NDIG);
   localparam int CW = $clog2(SCAN_DIV);

   // Last count of a slot, last lit count of a slot, and last digit index.
   // With DEAD == 0 the two counts coincide and the slot-end test wins.
   localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] ON_LAST  = CW'(SCAN_DIV - DEAD - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ON   = 2'd1,
      ST_DEAD = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [IW-1:0]     idx, idx_nxt;
   logic [CW-1:0]     cnt, cnt_nxt;
   logic              slot_end;
   logic              boundary;

   logic [4*NDIG-1:0] active, active_nxt;
   logic [4*NDIG-1:0] pending, pending_nxt;
   logic              pend, pend_nxt;

   logic [NDIG-1:0]   onehot_nxt;
   logic [NDIG-1:0]   blank;
   logic [3:0]        digit_sel;
   logic [NDIG-1:0]   dig_en_nxt;
   logic [3:0]        hex_nxt;

   // Scan state register: state, digit index and in-slot cycle counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         idx   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state logic; flags the frame boundary (IDLE entry or last slot end)
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      cnt_nxt   = cnt;
      slot_end  = 1'b0;
      boundary  = 1'b0;
      if (!ena) begin
         state_nxt = ST_IDLE;
         idx_nxt   = '0;
         cnt_nxt   = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               state_nxt = ST_ON;
               idx_nxt   = '0;
               cnt_nxt   = '0;
               boundary  = 1'b1;
            end
            ST_ON: begin
               if (cnt == CNT_LAST) begin
                  slot_end = 1'b1;
               end else begin
                  cnt_nxt = cnt + 1'b1;
                  if (cnt == ON_LAST) begin
                     state_nxt = ST_DEAD;
                  end
               end
            end
            ST_DEAD: begin
               if (cnt == CNT_LAST) begin
                  slot_end = 1'b1;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            default: begin
               state_nxt = ST_IDLE;
               idx_nxt   = '0;
               cnt_nxt   = '0;
            end
         endcase
         if (slot_end) begin
            state_nxt = ST_ON;
            cnt_nxt   = '0;
            if (idx == IDX_LAST) begin
               idx_nxt  = '0;
               boundary = 1'b1;
            end else begin
               idx_nxt = idx + 1'b1;
            end
         end
      end
   end

   // Double buffer: a load on a boundary bypasses pending straight to active
   always_comb begin
      active_nxt  = active;
      pending_nxt = pending;
      pend_nxt    = pend;
      if (boundary) begin
         if (load) begin
            active_nxt = digits_in;
            pend_nxt   = 1'b0;
         end else if (pend) begin
            active_nxt = pending;
            pend_nxt   = 1'b0;
         end
      end else if (load) begin
         pending_nxt = digits_in;
         pend_nxt    = 1'b1;
      end
   end

   // Buffer registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active  <= '0;
         pending <= '0;
         pend    <= 1'b0;
      end else begin
         active  <= active_nxt;
         pending <= pending_nxt;
         pend    <= pend_nxt;
      end
   end

   // Outputs are derived from next-cycle values so they can be registered
   // without lagging the state by one cycle.
   assign onehot_nxt = {{(NDIG-1){1'b0}}, 1'b1} << idx_nxt;
   assign digit_sel  = active_nxt[{idx_nxt, 2'b00} +: 4];

`ifdef SEG_SCAN_LZB_EN
   // A digit is blanked when it and every more significant digit are zero;
   // digit 0 always stays lit so a zero value still shows "0".
   assign blank[0] = 1'b0;
   for (genvar k = 1; k < NDIG; k++) begin : g_lzb
      assign blank[k] = ~|active_nxt[4*NDIG-1:4*k];
   end
`else
   assign blank = '0;
`endif

   // Output decode: enables only in ON, hex value holds through DEAD/IDLE
   always_comb begin
      dig_en_nxt = '0;
      hex_nxt    = hex_out;
      if (state_nxt == ST_ON) begin
         dig_en_nxt = onehot_nxt & ~blank;
         hex_nxt    = digit_sel;
      end
   end

   // Registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dig_en      <= '0;
         hex_out     <= '0;
         frame_start <= 1'b0;
         busy        <= 1'b0;
      end else begin
         dig_en      <= dig_en_nxt;
         hex_out     <= hex_nxt;
         frame_start <= boundary;
         busy        <= pend_nxt;
      end
   end

endmodule
`default_nettype wire
